// File: rtl/dmem_dump_reader.sv
// -----------------------------------------------------------------------------
// dmem_dump_reader
//
// Debug read-out engine for the CPU data memory. After a run it walks a
// contiguous word range through a synchronous-read port (1-cycle latency)
// and streams each 32-bit word as big-endian bytes on a valid/ready link.
//
// Ports
//   clock, resetn          single clock, asynchronous active-low reset
//   start                  one-cycle request, only honoured in IDLE
//   base_addr [ADDR_W]     first word address (latched on accepted start)
//   count     [ADDR_W+1]   number of words, 0..2^ADDR_W (latched on start)
//   mem_rd_en, mem_addr    read strobe / word address to data memory
//   mem_rdata [32]         read data, valid the cycle after mem_rd_en
//   out_valid/out_ready    byte stream handshake
//   out_byte  [8]          stream byte, MSB byte of each word first
//   out_last               final byte of the dump (qualified by out_valid)
//   busy                   high whenever not IDLE
//   done                   one-cycle pulse at end of dump
// -----------------------------------------------------------------------------
module dmem_dump_reader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;       // next word address to read
    logic [ADDR_W-1:0] last_addr_q;  // address of the most recent read strobe
    logic [ADDR_W:0]   remaining_q;  // words still to send, incl. current one
    logic [31:0]       shift_q;      // current word, MSB byte at [31:24]
    logic [1:0]        byte_idx_q;   // bytes of current word already accepted

    logic fire;
    logic word_end;

    assign fire     = (state_q == S_SEND) && out_ready;
    assign word_end = fire && (byte_idx_q == 2'd3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        // Address port holds the last strobed address between reads so the
        // memory sees no spurious address toggles while idle or streaming.
        mem_addr  = last_addr_q;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_byte  = shift_q[31:24];
                out_last  = (byte_idx_q == 2'd3) &&
                            (remaining_q == (ADDR_W+1)'(1));
                if (word_end) begin
                    // remaining_q==1 means the decrement below empties it
                    state_d = (remaining_q == (ADDR_W+1)'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= count;
                    end
                end
                S_READ: begin
                    last_addr_q <= addr_q;
                end
                S_WAIT: begin
                    shift_q    <= mem_rdata;
                    byte_idx_q <= '0;
                end
                S_SEND: begin
                    if (fire) begin
                        shift_q    <= {shift_q[23:0], 8'h00};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            addr_q      <= addr_q + ADDR_W'(1);
                            remaining_q <= remaining_q - (ADDR_W+1)'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
